// File: rtl/archie_loader_pkg.sv
// archie_loader_pkg: shared types and constants for the ioctl download loader.
// Holds the FIFO word record, byte-lane constants, the wishbone FSM states
// and a helper that builds a FIFO entry from a pending word.
package archie_loader_pkg;

  typedef struct packed {
    logic [25:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } loader_word_t;

  localparam logic [3:0] SEL_LO  = 4'b0011;
  localparam logic [3:0] SEL_HI  = 4'b1100;
  localparam logic [3:0] SEL_ALL = 4'b1111;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } loader_state_e;

  // Builds a FIFO entry; the word index is a 32-bit word number inside the image.
  function automatic loader_word_t make_word(input logic [25:0] base,
                                             input logic [21:0] word,
                                             input logic [3:0]  sel,
                                             input logic [31:0] dat);
    loader_word_t w;
    w.adr = base + {2'b00, word, 2'b00};
    w.sel = sel;
    w.dat = dat;
    return w;
  endfunction

endpackage

// File: rtl/loader_fifo.sv
// loader_fifo: small synchronous FIFO of loader_word_t entries.
// DEPTH must be a power of two (pointers wrap naturally). A push while full
// is accepted only when a pop happens in the same cycle.
module loader_fifo
  import archie_loader_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          push_i,
  input  loader_word_t  din_i,
  input  logic          pop_i,
  output loader_word_t  dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  loader_word_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write port.
  // NOTE: the data array is deliberately not reset; occupancy is tracked by
  // the pointers, so stale contents are never observed and no reset fan-out is needed.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ioctl_wb_loader.sv
// ioctl_wb_loader: packs 16-bit hps_io download writes for one ioctl index
// into 32-bit wishbone classic write cycles through a small word FIFO.
// Optional feature macro: LOADER_CHECKSUM_EN adds a running checksum output
// of every acked word (unselected lanes counted as zero).
module ioctl_wb_loader
  import archie_loader_pkg::*;
#(
  parameter logic [7:0]  INDEX      = 8'd1,
  parameter logic [25:0] BASE_ADDR  = 26'h400000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic        bus_req,
  output logic        done,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [25:0] wb_adr,
  output logic [31:0] wb_dat_o,
  output logic [2:0]  wb_cti,
  input  logic        wb_ack
`ifdef LOADER_CHECKSUM_EN
  , output logic [31:0] checksum
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] WAIT_LVL = CW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Download qualification and edge detect.
  logic active;
  logic active_q;
  logic active_rise;
  assign active      = ioctl_download && (ioctl_index == INDEX);
  assign active_rise = active && !active_q;

  // Incoming halfword mapped onto its lane.
  logic        hw_hi;
  logic [3:0]  hw_sel;
  logic [31:0] hw_dat;
  logic [21:0] hw_word;
  logic        unused_addr;
  assign hw_hi       = ioctl_addr[1];
  assign hw_sel      = hw_hi ? SEL_HI : SEL_LO;
  assign hw_dat      = hw_hi ? {ioctl_dout, 16'h0000} : {16'h0000, ioctl_dout};
  assign hw_word     = ioctl_addr[23:2];
  assign unused_addr = ^{ioctl_addr[24], ioctl_addr[0]};

  // Pending partial word.
  logic        pend_v_q,    pend_v_d;
  logic [21:0] pend_word_q, pend_word_d;
  logic [31:0] pend_dat_q,  pend_dat_d;
  logic [3:0]  pend_sel_q,  pend_sel_d;

  // FIFO interface.
  logic          push;
  loader_word_t  push_entry;
  logic          pop;
  loader_word_t  fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  // Wishbone master registers.
  loader_state_e state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q,  we_d;
  logic [3:0]    sel_q, sel_d;
  logic [25:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;

  // Completion tracking.
  logic pushed_q, pushed_d;
  logic done_q,   done_d;
  logic bus_req_q, bus_req_d;

  // Pending-word update and FIFO push decision (one push per cycle at most).
  // NOTE: combinational blocks use blocking assignments and give every output a
  // default first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    pend_v_d    = pend_v_q;
    pend_word_d = pend_word_q;
    pend_dat_d  = pend_dat_q;
    pend_sel_d  = pend_sel_q;
    push        = 1'b0;
    push_entry  = make_word(BASE_ADDR, pend_word_q, pend_sel_q, pend_dat_q);
    if (ioctl_wr && active) begin
      if (!pend_v_q) begin
        pend_v_d    = 1'b1;
        pend_word_d = hw_word;
        pend_dat_d  = hw_dat;
        pend_sel_d  = hw_sel;
      end else if ((hw_word == pend_word_q) && ((pend_sel_q & hw_sel) == 4'b0000)) begin
        // Two disjoint halfword lanes always complete the word.
        push       = 1'b1;
        push_entry = make_word(BASE_ADDR, pend_word_q, pend_sel_q | hw_sel,
                               pend_dat_q | hw_dat);
        pend_v_d   = 1'b0;
      end else begin
        push        = 1'b1;
        pend_v_d    = 1'b1;
        pend_word_d = hw_word;
        pend_dat_d  = hw_dat;
        pend_sel_d  = hw_sel;
      end
    end else if (!active && pend_v_q && !fifo_full) begin
      // Flush the trailing partial word once the download has ended.
      push     = 1'b1;
      pend_v_d = 1'b0;
    end
  end

  loader_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Wishbone FSM next state: launch from the FIFO head, hold until ack.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          sel_d   = fifo_head.sel;
          adr_d   = fifo_head.adr;
          dat_d   = fifo_head.dat;
          state_d = REQ;
        end
      end
      REQ: begin
        if (wb_ack) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion pulse and port ownership, computed from next-cycle state.
  assign done_d    = !active && pushed_q && fifo_empty && !pend_v_q && (state_q == IDLE);
  assign pushed_d  = push ? 1'b1 : ((done_d || active_rise) ? 1'b0 : pushed_q);
  assign bus_req_d = active || pend_v_d || push ||
                     (!fifo_empty && !(pop && (fifo_count == CNT_ONE))) ||
                     (state_d != IDLE);

  // State registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      active_q    <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_word_q <= '0;
      pend_dat_q  <= '0;
      pend_sel_q  <= '0;
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      pushed_q    <= 1'b0;
      done_q      <= 1'b0;
      bus_req_q   <= 1'b0;
    end else begin
      active_q    <= active;
      pend_v_q    <= pend_v_d;
      pend_word_q <= pend_word_d;
      pend_dat_q  <= pend_dat_d;
      pend_sel_q  <= pend_sel_d;
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      pushed_q    <= pushed_d;
      done_q      <= done_d;
      bus_req_q   <= bus_req_d;
    end
  end

  assign ioctl_wait = active && (fifo_count >= WAIT_LVL);
  assign bus_req    = bus_req_q;
  assign done       = done_q;
  assign wb_cyc     = cyc_q;
  assign wb_stb     = stb_q;
  assign wb_we      = we_q;
  assign wb_sel     = sel_q;
  assign wb_adr     = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_cti     = 3'b000;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;
  logic [31:0] acked_masked;
  assign acked_masked = dat_q & {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};

  // Running sum of acked words, restarted with each new download.
  always_ff @(posedge clk_sys) begin
    if (reset || active_rise) checksum_q <= '0;
    else if (pop)             checksum_q <= checksum_q + acked_masked;
  end

  assign checksum = checksum_q;
`endif

  // hps_io must honour ioctl_wait, so a push never lands in a full FIFO.
  a_no_overflow: assert property (@(posedge clk_sys) disable iff (reset)
                                  !(push && fifo_full && !pop));

endmodule

// File: tb/tb_ioctl_wb_loader.sv
// tb_ioctl_wb_loader: scoreboard bench for ioctl_wb_loader. Expected wishbone
// words are queued as writes are driven and popped when the slave model acks.
module tb_ioctl_wb_loader;
  import archie_loader_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic        ioctl_wait;
  logic        bus_req;
  logic        done;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [25:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [2:0]  wb_cti;
  logic        wb_ack = 1'b0;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  always #5 clk_sys = ~clk_sys;

  ioctl_wb_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .bus_req        (bus_req),
    .done           (done),
    .wb_cyc         (wb_cyc),
    .wb_stb         (wb_stb),
    .wb_we          (wb_we),
    .wb_sel         (wb_sel),
    .wb_adr         (wb_adr),
    .wb_dat_o       (wb_dat_o),
    .wb_cti         (wb_cti),
    .wb_ack         (wb_ack)
`ifdef LOADER_CHECKSUM_EN
    , .checksum     (checksum)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int ack_delay = 0;
  int ack_cnt = 0;
  int done_cnt = 0;
  int stall_cnt = 0;
  loader_word_t exp_q[$];
  loader_word_t mon_exp;
  bit           hold_v = 1'b0;
  logic [25:0]  hold_adr;
  logic [31:0]  hold_dat;

  // Slave model and scoreboard: ack after ack_delay stall cycles, compare on ack.
  always @(negedge clk_sys) begin
    if (reset) begin
      wb_ack    = 1'b0;
      stall_cnt = 0;
      hold_v    = 1'b0;
    end else if (wb_ack) begin
      wb_ack = 1'b0;
      hold_v = 1'b0;
    end else if (wb_cyc && wb_stb) begin
      if (hold_v) begin
        n_cmp++;
        if (wb_adr !== hold_adr || wb_dat_o !== hold_dat) begin
          n_err++;
          $display("FAIL req_stable: adr %h dat %h, held %h %h", wb_adr, wb_dat_o, hold_adr, hold_dat);
        end
      end else begin
        hold_v   = 1'b1;
        hold_adr = wb_adr;
        hold_dat = wb_dat_o;
      end
      if (stall_cnt >= ack_delay) begin
        stall_cnt = 0;
        wb_ack    = 1'b1;
        ack_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL wb_unexpected: adr %h sel %b dat %h, no write expected", wb_adr, wb_sel, wb_dat_o);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({wb_adr, wb_sel, wb_dat_o, wb_we, wb_cti} !== {mon_exp.adr, mon_exp.sel, mon_exp.dat, 1'b1, 3'b000}) begin
            n_err++;
            $display("FAIL wb_write: got adr %h sel %b dat %h we %b cti %b, want adr %h sel %b dat %h we 1 cti 000",
                     wb_adr, wb_sel, wb_dat_o, wb_we, wb_cti, mon_exp.adr, mon_exp.sel, mon_exp.dat);
          end
        end
      end else begin
        stall_cnt++;
      end
    end
    if (done) done_cnt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic exp_word(input logic [25:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    loader_word_t w;
    w.adr = adr;
    w.sel = sel;
    w.dat = dat;
    exp_q.push_back(w);
  endtask

  task automatic hps_write(input logic [24:0] a, input logic [15:0] d);
    int t = 0;
    while (ioctl_wait && t < 200) begin
      tick();
      t++;
    end
    if (ioctl_wait) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_timeout: ioctl_wait still %b after %0d cycles, want 0", ioctl_wait, t);
    end
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    tick();
  endtask

  task automatic end_and_drain(input int budget, input string tag);
    int t = 0;
    ioctl_download = 1'b0;
    tick(2);
    while ((exp_q.size() != 0 || bus_req) && t < budget) begin
      tick();
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || bus_req !== 1'b0) begin
      n_err++;
      $display("FAIL drain_%s: %0d writes outstanding, bus_req %b, want 0 and 0", tag, exp_q.size(), bus_req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    n_cmp++;
    if ({wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o, wb_cti} !== '0) begin
      n_err++;
      $display("FAIL reset_wb: cyc %b stb %b we %b sel %b adr %h dat %h cti %b, want all 0",
               wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o, wb_cti);
    end
    n_cmp++;
    if ({ioctl_wait, bus_req, done} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_ctl: wait %b bus_req %b done %b, want 000", ioctl_wait, bus_req, done);
    end
    reset = 1'b0;
    tick(2);
    n_cmp++;
    if ({wb_cyc, bus_req, done} !== 3'b000) begin
      n_err++;
      $display("FAIL post_reset_idle: cyc %b bus_req %b done %b, want 000", wb_cyc, bus_req, done);
    end
  endtask

  task automatic test_pack();
    done_cnt = 0;
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    exp_word(26'h400000, 4'b1111, 32'hABCD1234);
    hps_write(25'h0, 16'h1234);
    hps_write(25'h2, 16'hABCD);
    end_and_drain(50, "pack");
    tick(5);
    n_cmp++;
    if (done_cnt != 1) begin
      n_err++;
      $display("FAIL pack_done: %0d done pulses, want 1", done_cnt);
    end
  endtask

  task automatic test_single_end();
    int acks_before;
    int acks_at_done = -1;
    int t = 0;
    done_cnt = 0;
    ioctl_download = 1'b1;
    exp_word(26'h400004, 4'b1100, 32'h5555_0000);
    acks_before = ack_cnt;
    hps_write(25'h6, 16'h5555);
    tick(5);
    n_cmp++;
    if (ack_cnt != acks_before || wb_cyc !== 1'b0 || done_cnt != 0) begin
      n_err++;
      $display("FAIL single_held: acks %0d cyc %b done %0d while active, want %0d 0 0",
               ack_cnt, wb_cyc, done_cnt, acks_before);
    end
    end_and_drain(50, "single");
    while (done_cnt == 0 && t < 20) begin
      tick();
      t++;
    end
    acks_at_done = ack_cnt;
    tick(10);
    n_cmp++;
    if (done_cnt != 1 || acks_at_done != acks_before + 1) begin
      n_err++;
      $display("FAIL single_done: %0d pulses with %0d acks before it, want 1 pulse after %0d acks",
               done_cnt, acks_at_done - acks_before, 1);
    end
  endtask

  task automatic test_two_words();
    ioctl_download = 1'b1;
    exp_word(26'h400000, 4'b0011, 32'h0000_1111);
    exp_word(26'h400008, 4'b0011, 32'h0000_2222);
    hps_write(25'h0, 16'h1111);
    hps_write(25'h8, 16'h2222);
    end_and_drain(60, "two_words");
  endtask

  task automatic test_overlap();
    ioctl_download = 1'b1;
    exp_word(26'h400004, 4'b0011, 32'h0000_AAAA);
    exp_word(26'h400004, 4'b0011, 32'h0000_BBBB);
    exp_word(26'h400000, 4'b1111, 32'h0001_0002);
    hps_write(25'h4, 16'hAAAA);
    hps_write(25'h4, 16'hBBBB);
    hps_write(25'h2, 16'h0001);
    hps_write(25'h0, 16'h0002);
    end_and_drain(60, "overlap");
  endtask

  task automatic test_burst();
    logic [15:0] lo;
    logic [15:0] hi;
    ack_delay = 20;
    ioctl_download = 1'b1;
    for (int k = 0; k < 8; k++) begin
      lo = 16'hC000 + 16'(2 * k);
      hi = 16'hC000 + 16'(2 * k + 1);
      exp_word(26'h400000 + 26'(4 * k), 4'b1111, {hi, lo});
    end
    for (int i = 0; i < 16; i++) begin
      hps_write(25'(2 * i), 16'hC000 + 16'(i));
      if (i == 3 || i == 4) begin
        n_cmp++;
        if (ioctl_wait !== 1'b0) begin
          n_err++;
          $display("FAIL burst_wait_early: after %0d writes wait %b, want 0", i + 1, ioctl_wait);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if (ioctl_wait !== 1'b1) begin
          n_err++;
          $display("FAIL burst_wait_at3: after 6 writes wait %b, want 1", ioctl_wait);
        end
      end
    end
    end_and_drain(600, "burst");
    ack_delay = 0;
  endtask

  task automatic test_other_index();
    int acks_before = ack_cnt;
    bit bad = 1'b0;
    ioctl_index = 8'd3;
    ioctl_download = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hps_write(25'(2 * i), 16'h7000 + 16'(i));
      if (bus_req !== 1'b0 || ioctl_wait !== 1'b0 || wb_cyc !== 1'b0) bad = 1'b1;
    end
    ioctl_download = 1'b0;
    tick(10);
    n_cmp++;
    if (bad || ack_cnt != acks_before || bus_req !== 1'b0) begin
      n_err++;
      $display("FAIL other_index: activity seen %b, acks %0d, bus_req %b, want 0 %0d 0",
               bad, ack_cnt, bus_req, acks_before);
    end
    ioctl_index = 8'd1;
  endtask

  task automatic test_back_to_back();
    ack_delay = 6;
    ioctl_download = 1'b1;
    exp_word(26'h400000, 4'b1111, 32'h2222_1111);
    exp_word(26'h400004, 4'b1111, 32'h4444_3333);
    exp_word(26'h400010, 4'b1111, 32'h6666_5555);
    hps_write(25'h0, 16'h1111);
    hps_write(25'h2, 16'h2222);
    hps_write(25'h4, 16'h3333);
    hps_write(25'h6, 16'h4444);
    ioctl_download = 1'b0;
    tick();
    ioctl_download = 1'b1;
    hps_write(25'h10, 16'h5555);
    hps_write(25'h12, 16'h6666);
    end_and_drain(200, "back_to_back");
    ack_delay = 0;
  endtask

  task automatic test_reset_mid();
    int t = 0;
    bit bad = 1'b0;
    ack_delay = 1000;
    ioctl_download = 1'b1;
    exp_word(26'h400000, 4'b1111, 32'h0B0B_0A0A);
    exp_word(26'h400004, 4'b1111, 32'h0D0D_0C0C);
    hps_write(25'h0, 16'h0A0A);
    hps_write(25'h2, 16'h0B0B);
    hps_write(25'h4, 16'h0C0C);
    hps_write(25'h6, 16'h0D0D);
    while (!wb_cyc && t < 20) begin
      tick();
      t++;
    end
    n_cmp++;
    if (wb_cyc !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_req: cyc %b before reset, want 1", wb_cyc);
    end
    ioctl_download = 1'b0;
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({wb_cyc, wb_stb, bus_req, ioctl_wait} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_mid_drop: cyc %b stb %b bus_req %b wait %b, want 0000",
               wb_cyc, wb_stb, bus_req, ioctl_wait);
    end
    reset = 1'b0;
    exp_q.delete();
    ack_delay = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (wb_cyc !== 1'b0 || bus_req !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL reset_mid_empty: wishbone or bus_req activity after reset, want none");
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    ioctl_download = 1'b1;
    exp_word(26'h400000, 4'b1111, 32'h0000_0001);
    exp_word(26'h400004, 4'b1111, 32'h0000_0002);
    hps_write(25'h0, 16'h0001);
    hps_write(25'h2, 16'h0000);
    hps_write(25'h4, 16'h0002);
    hps_write(25'h6, 16'h0000);
    end_and_drain(60, "checksum");
    n_cmp++;
    if (checksum !== 32'd3) begin
      n_err++;
      $display("FAIL checksum_sum: got %h, want 00000003", checksum);
    end
    ioctl_download = 1'b1;
    tick(3);
    n_cmp++;
    if (checksum !== 32'd0) begin
      n_err++;
      $display("FAIL checksum_clear: got %h after new download, want 00000000", checksum);
    end
    ioctl_download = 1'b0;
    tick(3);
  endtask
`endif

  initial begin
    test_reset();
    test_pack();
    test_single_end();
    test_two_words();
    test_overlap();
    test_burst();
    test_other_index();
    test_back_to_back();
    test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ioctl_wb_loader.md
Name: ioctl_wb_loader

Overview:
- Upstream stage of the SDRAM wishbone slave: converts HPS ioctl 16-bit download writes for one ioctl index (RISC OS ROM image) into 32-bit wishbone write cycles.
- Packs adjacent halfwords into full words, buffers them in a small FIFO, and stalls the HPS via ioctl_wait.
- Owns the SDRAM port while the download is active or still draining; top level muxes the SDRAM port on bus_req and holds the core off the bus meanwhile.

Parameters:
- INDEX, 1: ioctl_index value this loader responds to.
- BASE_ADDR, 26'h400000: byte address added to ioctl_addr.
- FIFO_DEPTH, 4: word FIFO entries; power of two, at least 2.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download target index.
- ioctl_wr  in  1  one-cycle write strobe.
- ioctl_addr  in  25  byte address; bit 0 ignored.
- ioctl_dout  in  16  halfword data.
- ioctl_wait  out  1  stall request to hps_io.
- bus_req  out  1  loader owns the SDRAM port.
- done  out  1  one-cycle pulse when the drain completes.
- wb_cyc  out  1  wishbone cycle.
- wb_stb  out  1  wishbone strobe.
- wb_we  out  1  always 1 while wb_stb is high, else 0.
- wb_sel  out  4  byte lanes.
- wb_adr  out  26  byte address, bits [1:0] = 0.
- wb_dat_o  out  32  write data.
- wb_cti  out  3  constant 3'b000 (classic cycle).
- wb_ack  in  1  slave acknowledge.

Behaviour:
- Clock and reset: clk_sys, synchronous active-high reset.
- active = ioctl_download && (ioctl_index == INDEX).
- Reset values:
  - All outputs 0 (wb_cti 0).
  - FIFO empty, pending register invalid, FSM in IDLE.
  - Reset mid-cycle drops stb/cyc on the next edge. No ack is awaited; a late ack is ignored.
- Pending register holds one partial word: pend_v, pend_word (ioctl_addr[23:2]), pend_dat (32 bits), pend_sel (4 bits).
- Halfword mapping: ioctl_addr[1]=0 goes to bits [15:0] with sel 0011; ioctl_addr[1]=1 goes to bits [31:16] with sel 1100.
- On ioctl_wr && active, exactly one of these applies:
  - No pending word: load the halfword into pending.
  - Pending, same word, lanes disjoint: merge. If the merged sel is 1111, push it to the FIFO and clear pending.
  - Pending, different word or overlapping lanes: push pending unchanged, then load the new halfword into pending.
- At most one FIFO push per cycle.
- FIFO entry = {adr = BASE_ADDR + {pend_word,2'b00}, sel, dat}. Address arithmetic is 26-bit, wrap-around ignored.
- ioctl_wait = active && (fifo_count >= FIFO_DEPTH-1). This keeps one slot free for a write already in flight.
- A push into a full FIFO cannot occur when hps_io honours ioctl_wait. The RTL carries an assertion for it.
- Download end (active falls): if pend_v, push pending on the next cycle the FIFO is not full.
- Drain completes when the FIFO is empty, pend_v=0 and FSM=IDLE. done pulses one cycle, only if at least one word was pushed since active rose.
- bus_req = active || pend_v || fifo non-empty || FSM != IDLE.
- Wishbone FSM:
  - IDLE: if FIFO non-empty, latch the head into the output registers, assert cyc/stb/we, go to REQ.
  - REQ: hold all outputs stable until wb_ack. On ack: drop cyc/stb/we, pop the FIFO, go to IDLE.
  - Minimum of one idle cycle between cycles.
- Simultaneous push and pop in the same cycle are both honoured; count is unchanged.
- active rising while still draining a previous download: new writes are accepted normally; ordering is preserved.

Optional Feature:
- LOADER_CHECKSUM_EN defined:
  - Adds output checksum (32 bits): running sum of the 32-bit words acked on the wishbone, with unselected lanes counted as 0.
  - The sum clears on the rising edge of active and on reset.
- Undefined: no port, no logic.

Decomposition:
- Shared package archie_loader_pkg:
  - typedef loader_word_t {adr[25:0], sel[3:0], dat[31:0]}.
  - Lane constants SEL_LO=4'b0011, SEL_HI=4'b1100, SEL_ALL=4'b1111.
  - FSM state enum {IDLE, REQ}.
- One sub-module, loader_fifo: synchronous FIFO of loader_word_t with count, full and empty outputs, parameterised by FIFO_DEPTH.

Test Plan:
- Writes addr 0 data 16'h1234, then addr 2 data 16'hABCD (index 1) -> one wishbone write: adr 26'h400000, sel 1111, dat 32'hABCD1234.
- Single write addr 6 data 16'h5555, then download ends -> one write: adr 26'h400004, sel 1100, dat[31:16]=16'h5555; done pulses once, after the ack.
- Writes at addr 0 then addr 8 -> two writes: sel 0011 at 26'h400000, then sel 0011 at 26'h400008.
- Slave holds ack low for 20 cycles during a burst of 16 writes -> ioctl_wait rises when the count reaches 3 (depth 4); no data is lost; adr and dat stay stable through each REQ.
- ioctl_index=3 with writes -> no wishbone activity; bus_req=0; ioctl_wait=0.
- Reset asserted during REQ -> next cycle cyc/stb=0, FIFO empty, bus_req=0. With LOADER_CHECKSUM_EN: words 1 and 2 acked give checksum 3.
